// File: rtl/ipf_pkg.sv
// Shared constants and types for the RGB-to-gray frame converter.
package ipf_pkg;
    localparam int N_PIX = 16384;
    localparam int AW    = 14;
    localparam int W_R   = 77;
    localparam int W_G   = 150;
    localparam int W_B   = 29;
    localparam int RND   = 128;

    typedef enum logic [1:0] {FILL, DRAIN, SERVE} state_t;
endpackage

// File: rtl/gray_conv_if.sv
// Pixel input stream and frame-buffer read port of the gray converter.
interface gray_conv_if #(parameter int AW = 14);
    logic          rgb_valid;
    logic [23:0]   rgb_data;
    logic          rgb_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          gray_ready;
    logic [7:0]    gray_data;
    logic          finish;
    logic          frame_done;

    modport slave (
        input  rgb_valid, rgb_data, gray_req, gray_addr, finish,
        output rgb_ready, gray_ready, gray_data, frame_done
    );
    modport master (
        output rgb_valid, rgb_data, gray_req, gray_addr, finish,
        input  rgb_ready, gray_ready, gray_data, frame_done
    );
endinterface

// File: rtl/gray_luma.sv
// Two-stage luma pipeline: weighted products, then rounded sum; gray = sum[15:8].
module gray_luma
    import ipf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    output logic [7:0]  out_gray
);
    localparam int STAGES = 2;

    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic [15:0]     p_r, p_g, p_b;
    logic [15:0]     sum;

    assign vld_pipe = {vld_q, in_valid};

    always_ff @(posedge clk) begin
        if (!reset) vld_q <= '0;
        else        vld_q <= vld_pipe[STAGES-1:0];
    end

    // Max sum is 65408, so 16 bits never overflow and no saturation is needed.
    always_ff @(posedge clk) begin
        p_r <= 16'(W_R * in_rgb[23:16]);
        p_g <= 16'(W_G * in_rgb[15:8]);
        p_b <= 16'(W_B * in_rgb[7:0]);
        sum <= p_r + p_g + p_b + 16'(RND);
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_gray  = sum[15:8];
endmodule

// File: rtl/gray_conv.sv
// Fills an N_PIX gray frame buffer from an RGB stream, then serves it to the IPF until finish.
module gray_conv
    import ipf_pkg::*;
#(
    parameter int N_PIX = ipf_pkg::N_PIX,
    parameter int AW    = ipf_pkg::AW
) (
    input  logic        clk,
    input  logic        reset,
    gray_conv_if.slave  bus
);
    state_t        state, state_nxt;
    logic [AW:0]   acc_cnt;
    logic [AW-1:0] wr_addr;
    logic          last_wr;
    logic          frame_done_q;
    logic          accept;
    logic          l_valid;
    logic [7:0]    l_gray;
    logic          wr_en;
    logic          release_buf;
    logic [7:0]    mem [N_PIX];

    assign bus.rgb_ready  = (state == FILL);
    assign bus.gray_ready = (state == SERVE);
    assign bus.frame_done = frame_done_q;

    assign accept      = bus.rgb_valid && (state == FILL);
    assign wr_en       = l_valid && (state != SERVE);
    assign release_buf = (state == SERVE) && bus.finish;

    gray_luma u_luma (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_rgb    (bus.rgb_data),
        .out_valid (l_valid),
        .out_gray  (l_gray)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && acc_cnt == (AW+1)'(N_PIX-1)) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = SERVE;
            SERVE:   if (bus.finish) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= FILL;
            acc_cnt      <= '0;
            wr_addr      <= '0;
            last_wr      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_wr      <= wr_en && (wr_addr == AW'(N_PIX-1));
            frame_done_q <= (state == DRAIN) && last_wr;
            if (release_buf)  acc_cnt <= '0;
            else if (accept)  acc_cnt <= acc_cnt + 1'b1;
            if (release_buf)  wr_addr <= '0;
            else if (wr_en)   wr_addr <= wr_addr + 1'b1;
        end
    end

    // Frame storage is deliberately not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_addr] <= l_gray;
    end

    always_comb begin
        bus.gray_data = 8'h00;
        if ((state == SERVE) && bus.gray_req && ({1'b0, bus.gray_addr} < (AW+1)'(N_PIX)))
            bus.gray_data = mem[bus.gray_addr];
    end
endmodule
